sort_cell_link_fifo: RTL
========================

Name: sort_cell_link_fifo

Overview:
- Channel block placed between consecutive insertion-sort cells in the dataflow chain.
- Acts as the responder for a cell's FIFO master ports. Its write side accepts a cell's out_V_din/out_V_write and returns out_V_full_n. Its read side presents in_V_dout/in_V_empty_n to the next cell and accepts in_V_read.
- Also carries the start-token channel: it absorbs the upstream start_write, returns start_full_n, and drives the downstream ap_start until the downstream cell's ap_ready consumes the token.

Parameters:
DATA_WIDTH, 32, width of stream words.
DEPTH, 4, data FIFO capacity in words; must be ≥2 and a power of two.
ADDR_WIDTH, 2, log2(DEPTH).
START_DEPTH, 2, maximum number of outstanding start tokens; must be ≥1.

Ports:
ap_clk  in  1  single clock; all state updates on rising edge.
ap_rst_n  in  1  asynchronous, active-low reset.
if_din  in  DATA_WIDTH  write data (from upstream out_V_din).
if_write  in  1  write strobe (from upstream out_V_write).
if_full_n  out  1  1 = space available (to upstream out_V_full_n).
if_dout  out  DATA_WIDTH  head word; valid while if_empty_n=1 (to downstream in_V_dout).
if_empty_n  out  1  1 = data available (to downstream in_V_empty_n).
if_read  in  1  read strobe (from downstream in_V_read).
if_num_data  out  ADDR_WIDTH+1  current data occupancy, 0..DEPTH.
start_write  in  1  start-token push from upstream.
start_full_n  out  1  1 = token slot free (to upstream start_full_n).
next_ap_start  out  1  1 = token pending (to downstream ap_start).
next_ap_ready  in  1  token pop (from downstream ap_ready).

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - Pointers, data count and token count clear to 0.
  - if_full_n=1, if_empty_n=0, if_dout=0, if_num_data=0.
  - start_full_n=1, next_ap_start=0.
  - Reset asserted mid-transfer discards all stored words and tokens immediately; no partial write survives.
- Storage: DEPTH-entry array with wrapping write and read pointers, plus a count register. Pointers wrap from DEPTH-1 to 0 with no gap.
- Accepted write = if_write & if_full_n. The word is stored at the write pointer, which then advances. A write while full is ignored: no store, no pointer move, no count change.
- Accepted read = if_read & if_empty_n. The read pointer advances. A read while empty is ignored.
- First-word-fall-through: if_dout always shows the head entry, combinationally from the array at the read pointer. A word written in cycle N is visible with if_empty_n=1 from cycle N+1. There is no same-cycle write-to-read bypass.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted in the same cycle.
- Flags are registered from the next count:
  - if_full_n = (count_next != DEPTH).
  - if_empty_n = (count_next != 0).
  - if_num_data = count.
- Simultaneous events:
  - Full with if_read and if_write both high: only the read is accepted; if_full_n rises the next cycle.
  - Empty with both high: only the write is accepted.
  - Partially full with both high: both are accepted and the count holds.
- Start-token counter (0..START_DEPTH):
  - Push = start_write & start_full_n.
  - Pop = next_ap_ready & next_ap_start.
  - Push and pop in the same cycle leave the count unchanged.
  - start_full_n = (tcount != START_DEPTH).
  - next_ap_start = (tcount != 0), registered.
  - A push while full and a pop while empty are both ignored.
- Data and token paths are fully independent; neither throttles the other.
- No state machine beyond the two counters. The block is always ready and has no idle or done outputs.

Test Plan:
1. Release reset, write 0x00000005, 0x00000003, 0x00000009 on consecutive cycles -> if_empty_n=1 from cycle after first write; reads return 5, 3, 9 in order; if_num_data goes 1,2,3 then drains to 0; if_empty_n=0 after the last read.
2. Write 4 words (DEPTH=4) -> if_full_n=0, if_num_data=4; a 5th write of 0xDEADBEEF is dropped; draining returns only the original 4 words.
3. Full FIFO with if_read=if_write=1 for one cycle -> one word leaves, new word is not stored, if_num_data=3, if_full_n=1 next cycle.
4. Count at 2, continuous read+write for 10 cycles with incrementing data 0x10..0x19 -> if_num_data stays 2; output order is strictly FIFO across pointer wrap.
5. Pulse start_write 3 times with next_ap_ready=0 (START_DEPTH=2) -> tokens=2, start_full_n=0, third push ignored; next_ap_ready pulses twice -> next_ap_start falls one cycle after the second pop.
6. Assert ap_rst_n=0 asynchronously mid-stream with 3 words and 1 token held -> flags take reset values without a clock edge; after release the FIFO reads empty and next_ap_start=0.

Source files
------------

// File: rtl/sort_cell_link_fifo.sv
// sort_cell_link_fifo
// Link channel between two consecutive insertion-sort cells. It carries two
// independent paths:
//   - a first-word-fall-through data FIFO that receives the upstream cell's
//     stream words and feeds the downstream cell's input port;
//   - a start-token counter that turns the upstream start_write pushes into a
//     level ap_start for the downstream cell. The downstream ap_ready consumes
//     one token.
//
// Ports
//   ap_clk         clock, all state updates on the rising edge
//   ap_rst_n       asynchronous active-low reset
//   if_din         write data from the upstream cell
//   if_write       write strobe from the upstream cell
//   if_full_n      1 = space available, returned to the upstream cell
//   if_dout        head word, valid while if_empty_n = 1
//   if_empty_n     1 = data available to the downstream cell
//   if_read        read strobe from the downstream cell
//   if_num_data    current data occupancy, 0..DEPTH
//   start_write    start-token push from the upstream cell
//   start_full_n   1 = token slot free
//   next_ap_start  1 = token pending, drives downstream ap_start
//   next_ap_ready  token pop from the downstream cell
module sort_cell_link_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int START_DEPTH = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [ADDR_WIDTH:0]   if_num_data,
  input  logic                  start_write,
  output logic                  start_full_n,
  output logic                  next_ap_start,
  input  logic                  next_ap_ready
);

  localparam int TOK_WIDTH = $clog2(START_DEPTH + 1);

  localparam logic [ADDR_WIDTH:0]  DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [TOK_WIDTH-1:0] TOK_MAX  = TOK_WIDTH'(START_DEPTH);
  localparam logic [TOK_WIDTH-1:0] TOK_ONE  = TOK_WIDTH'(1);

  // ---------------------------------------------------------------------
  // Data FIFO
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  full_n_q;
  logic                  empty_n_q;
  logic                  wr_en;
  logic                  rd_en;

  // Acceptance is qualified by the registered flags, so a full FIFO with
  // both strobes high accepts only the read, and an empty one only the write.
  assign wr_en = if_write & full_n_q;
  assign rd_en = if_read & empty_n_q;

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en)      count_next = count + CNT_ONE;
    else if (rd_en && !wr_en) count_next = count - CNT_ONE;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= if_din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_next;
      full_n_q  <= (count_next != DEPTH_C);
      empty_n_q <= (count_next != '0);
    end
  end

  // Fall-through head: no bypass, a fresh word appears one cycle after its write.
  assign if_dout     = mem[rd_ptr];
  assign if_full_n   = full_n_q;
  assign if_empty_n  = empty_n_q;
  assign if_num_data = count;

  // ---------------------------------------------------------------------
  // Start-token counter
  // ---------------------------------------------------------------------
  logic [TOK_WIDTH-1:0] tcount;
  logic [TOK_WIDTH-1:0] tcount_next;
  logic                 tok_full_n_q;
  logic                 tok_pending_q;
  logic                 push;
  logic                 pop;

  assign push = start_write & tok_full_n_q;
  assign pop  = next_ap_ready & tok_pending_q;

  always_comb begin
    tcount_next = tcount;
    if (push && !pop)      tcount_next = tcount + TOK_ONE;
    else if (pop && !push) tcount_next = tcount - TOK_ONE;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tcount        <= '0;
      tok_full_n_q  <= 1'b1;
      tok_pending_q <= 1'b0;
    end else begin
      tcount        <= tcount_next;
      tok_full_n_q  <= (tcount_next != TOK_MAX);
      tok_pending_q <= (tcount_next != '0);
    end
  end

  assign start_full_n  = tok_full_n_q;
  assign next_ap_start = tok_pending_q;

endmodule
